// File: rtl/dff_edge_pair.sv
// Paired rising/falling edge capture register with a live mismatch flag.
// Optional per-bank capture counters are enabled by defining DFF_EDGE_CNT_EN.
module dff_edge_pair #(
  parameter int unsigned       WIDTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0,
  parameter int unsigned       CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q_pos,
  output logic [WIDTH-1:0] o_q_neg,
  output logic             o_diff
`ifdef DFF_EDGE_CNT_EN
  ,
  output logic [CNT_W-1:0] o_cnt_pos,
  output logic [CNT_W-1:0] o_cnt_neg
`endif
);

  logic [WIDTH-1:0] r_q_pos;
  logic [WIDTH-1:0] r_q_neg;
  logic             w_diff;

  if (WIDTH < 1) begin : g_bad_width
    $error("dff_edge_pair: WIDTH must be at least 1");
  end

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("dff_edge_pair: CNT_W must be at least 1");
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q_pos <= RST_VAL;
    end else if (i_en) begin
      r_q_pos <= i_d;
    end
  end

  always_ff @(negedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q_neg <= RST_VAL;
    end else if (i_en) begin
      r_q_neg <= i_d;
    end
  end

  // Unregistered on purpose: pulses for a half cycle when i_d moves between edges.
  assign w_diff  = (r_q_pos != r_q_neg);
  assign o_q_pos = r_q_pos;
  assign o_q_neg = r_q_neg;
  assign o_diff  = w_diff;

`ifdef DFF_EDGE_CNT_EN
  logic [CNT_W-1:0] r_cnt_pos;
  logic [CNT_W-1:0] r_cnt_neg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt_pos <= '0;
    end else if (i_en) begin
      r_cnt_pos <= r_cnt_pos + CNT_W'(1);
    end
  end

  always_ff @(negedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt_neg <= '0;
    end else if (i_en) begin
      r_cnt_neg <= r_cnt_neg + CNT_W'(1);
    end
  end

  assign o_cnt_pos = r_cnt_pos;
  assign o_cnt_neg = r_cnt_neg;
`endif

endmodule

// File: tb/tb_dff_edge_pair.sv
// Scoreboard bench for dff_edge_pair: stimulus queues expectations,
// a monitor pops and compares them against the live DUT outputs.
`timescale 1ns/1ps
module tb_dff_edge_pair;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_en  = 1'b1;
  logic [0:0] i_d   = 1'b0;
  logic [0:0] o_q_pos;
  logic [0:0] o_q_neg;
  logic       o_diff;
`ifdef DFF_EDGE_CNT_EN
  logic [1:0] o_cnt_pos;
  logic [1:0] o_cnt_neg;
`endif

  dff_edge_pair #(
    .WIDTH  (1),
    .RST_VAL(1'b0),
    .CNT_W  (2)
  ) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (i_en),
    .i_d    (i_d),
    .o_q_pos(o_q_pos),
    .o_q_neg(o_q_neg),
    .o_diff (o_diff)
`ifdef DFF_EDGE_CNT_EN
    ,
    .o_cnt_pos(o_cnt_pos),
    .o_cnt_neg(o_cnt_neg)
`endif
  );

  // posedges at 5,15,25,...; negedges at 10,20,30,...
  always #5 i_clk = ~i_clk;

  typedef struct {
    string name;
    logic  pos;
    logic  neg;
    logic  diff;
    bit    has_cnt;
    int    cp;
    int    cn;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic at(input int t);
    if (t > $time) #(t - $time);
  endtask

  task automatic chk(input string nm, input logic p, input logic n);
    exp_t e;
    e.name = nm; e.pos = p; e.neg = n; e.diff = (p != n);
    e.has_cnt = 0; e.cp = 0; e.cn = 0;
    sb.push_back(e);
  endtask

  task automatic chk_cnt(input string nm, input logic p, input logic n,
                         input int cp, input int cn);
    exp_t e;
    e.name = nm; e.pos = p; e.neg = n; e.diff = (p != n);
    e.has_cnt = 1; e.cp = cp; e.cn = cn;
    sb.push_back(e);
  endtask

  // Monitor: outputs are sampled in the timestep the expectation is queued,
  // which stimulus always places away from clock edges and input changes.
  initial begin
    exp_t e;
    forever begin
      wait (sb.size() != 0);
      e = sb.pop_front();
      n_run++;
      if (o_q_pos !== e.pos || o_q_neg !== e.neg || o_diff !== e.diff) begin
        n_fail++;
        $display("FAIL %s @%0t: got pos=%b neg=%b diff=%b, want pos=%b neg=%b diff=%b",
                 e.name, $time, o_q_pos, o_q_neg, o_diff, e.pos, e.neg, e.diff);
      end
`ifdef DFF_EDGE_CNT_EN
      if (e.has_cnt) begin
        n_run++;
        if (int'(o_cnt_pos) != e.cp || int'(o_cnt_neg) != e.cn) begin
          n_fail++;
          $display("FAIL %s_cnt @%0t: got cnt_pos=%0d cnt_neg=%0d, want %0d %0d",
                   e.name, $time, o_cnt_pos, o_cnt_neg, e.cp, e.cn);
        end
      end
`endif
    end
  end

  logic m_pos, m_neg;
  int   P;

  initial begin
    // Establish known non-reset state: neg captures 0 at 10, pos captures 1 at 15
    at(11); i_d = 1'b1;
    at(16); chk("pre_rst", 1'b1, 1'b0);
    at(17); i_rst = 1'b1;
    at(18); chk("rst_async", 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      at(26 + 10*c); chk("rst_hold", 1'b0, 1'b0);
    end

    // Rising capture
    at(57); i_rst = 1'b0; i_d = 1'b0;
    at(58); chk("rel_no_edge", 1'b0, 1'b0);
    at(62); i_d = 1'b1;
    at(63); chk("rise_pre", 1'b0, 1'b0);
    at(66); chk("rise_pos", 1'b1, 1'b0);
    at(71); chk("rise_neg", 1'b1, 1'b1);

    // Falling capture
    at(77); i_d = 1'b0;
    at(78); chk("fall_pre", 1'b1, 1'b1);
    at(81); chk("fall_neg", 1'b1, 1'b0);
    at(86); chk("fall_pos", 1'b0, 1'b0);

    // Enable hold
    at(87); i_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      at(87 + 5*k); i_d = ~i_d;
      at(90 + 5*k + 1); chk("en_hold", 1'b0, 1'b0);
    end
    at(117); i_en = 1'b1; i_d = 1'b1;
    at(118); chk("en_pre", 1'b0, 1'b0);
    at(121); chk("en_neg", 1'b0, 1'b1);
    at(126); chk("en_pos", 1'b1, 1'b1);

`ifdef DFF_EDGE_CNT_EN
    // 5 captures per bank into a 2-bit counter wrap to 1
    at(136); i_rst = 1'b1;
    at(137); i_rst = 1'b0;
    at(186); chk_cnt("cnt_wrap", 1'b1, 1'b1, 1, 1);
    at(187); i_rst = 1'b1;
    at(188); chk_cnt("cnt_rst", 1'b0, 1'b0, 0, 0);
`endif

    at(191); i_rst = 1'b1;
    at(192); chk("rnd_init", 1'b0, 1'b0);
    m_pos = 1'b0; m_neg = 1'b0;

    // Random phase: changes at +2/+3 and +7/+8 ns after each posedge
    P = 195;
    for (int c = 0; c < 100; c++) begin
      at(P + 2 + int'($urandom_range(0, 1)));
      i_d   = 1'($urandom_range(0, 1));
      i_rst = ($urandom_range(0, 5) == 0);
      i_en  = ($urandom_range(0, 3) != 0);
      if (i_rst) begin m_pos = 1'b0; m_neg = 1'b0; end
      at(P + 4); chk("rnd_a", m_pos, m_neg);
      at(P + 6);
      if (i_rst) m_neg = 1'b0;
      else if (i_en) m_neg = i_d;
      chk("rnd_neg", m_pos, m_neg);
      at(P + 7 + int'($urandom_range(0, 1)));
      i_d   = 1'($urandom_range(0, 1));
      i_rst = ($urandom_range(0, 5) == 0);
      i_en  = ($urandom_range(0, 3) != 0);
      if (i_rst) begin m_pos = 1'b0; m_neg = 1'b0; end
      at(P + 9); chk("rnd_b", m_pos, m_neg);
      at(P + 11);
      if (i_rst) m_pos = 1'b0;
      else if (i_en) m_pos = i_d;
      chk("rnd_pos", m_pos, m_neg);
      P += 10;
    end

    for (int w = 0; w < 50 && sb.size() != 0; w++) #1;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/dff_edge_pair.md
Name: dff_edge_pair

Overview:
- Paired edge-capture register: one bank samples i_d on the rising clock edge, the other on the falling edge.
- Used wherever both half-cycle views of a signal are needed, e.g. half-cycle retiming or edge-alignment checks.
- Both banks share one clock and one asynchronous active-high reset.
- A combinational mismatch flag compares the two banks.

Parameters:
- WIDTH, 1, data width of i_d and of both capture banks.
- RST_VAL, 0 (WIDTH bits), value loaded into both banks while reset is asserted.
- CNT_W, 16, counter width; used only when DFF_EDGE_CNT_EN is defined.

Ports:
- i_clk  input  1  single clock; pos bank uses the rising edge, neg bank uses the falling edge.
- i_rst  input  1  asynchronous active-high reset shared by both banks.
- i_en  input  1  capture enable, sampled at each bank's own active edge.
- i_d  input  WIDTH  data to capture.
- o_q_pos  output  WIDTH  rising-edge capture bank.
- o_q_neg  output  WIDTH  falling-edge capture bank.
- o_diff  output  1  1 when o_q_pos != o_q_neg.
- o_cnt_pos  output  CNT_W  rising-edge capture count (only with DFF_EDGE_CNT_EN).
- o_cnt_neg  output  CNT_W  falling-edge capture count (only with DFF_EDGE_CNT_EN).

Behaviour:
- Interface (decided): one clock i_clk; reset i_rst is asynchronous and active-high.
- Reset values:
  - o_q_pos = o_q_neg = RST_VAL immediately on i_rst rising, no clock needed.
  - Both banks hold RST_VAL for as long as i_rst = 1.
  - o_diff = 0 during reset.
- Pos bank:
  - At each posedge i_clk with i_rst = 0 and i_en = 1: o_q_pos <= i_d.
  - With i_en = 0: holds its value.
- Neg bank:
  - At each negedge i_clk with i_rst = 0 and i_en = 1: o_q_neg <= i_d.
  - With i_en = 0: holds its value.
- Latency: i_d appears at o_q_pos after the next rising edge, and at o_q_neg after the next falling edge. There is no further pipelining.
- Reset release:
  - Release is asynchronous.
  - The first capture happens at the first active edge of each bank after i_rst falls.
  - An edge coincident with release captures nothing; the bank stays at RST_VAL.
- Reset mid-operation: both banks clear at once, even mid-phase. Any pending half-cycle capture is lost.
- Data changing between edges has no effect until the next active edge. Each bank samples exactly once per clock period.
- o_diff: combinational bitwise comparison of the two banks, no registering. It may pulse for a half cycle whenever i_d changes between edges.
- No X-propagation handling required beyond standard flop semantics.

Optional Feature:
- Macro: DFF_EDGE_CNT_EN.
- Defined:
  - o_cnt_pos increments on each rising-edge capture (i_en = 1, i_rst = 0); o_cnt_neg does the same on falling-edge captures.
  - Counters wrap modulo 2^CNT_W.
  - Both counters reset asynchronously to 0 with i_rst.
- Not defined: counter ports and logic are absent. All other behaviour is identical.

Test Plan:
- Reset: WIDTH=1, RST_VAL=0, drive i_d=1, assert i_rst mid-high-phase -> o_q_pos = o_q_neg = 0 immediately (no edge), o_diff=0; hold 4 cycles -> outputs stay 0.
- Rising capture: release reset, i_en=1, i_d=1 set 2 ns after a negedge (10 ns period) -> o_q_pos=1 at the next posedge, o_q_neg still 0, o_diff=1 until the following negedge, where o_q_neg=1 and o_diff=0.
- Falling capture: i_d changes 1->0 2 ns after a posedge -> o_q_neg=0 at the next negedge, o_q_pos=1 until the next posedge.
- Enable: i_en=0, toggle i_d for 3 cycles -> both banks hold their prior values; re-assert i_en=1 with i_d=1 -> captured at the next respective edges.
- Random: 100 cycles, i_d and i_rst randomized at 0-100% phase offset within each cycle -> compare against a reference model: the pos value equals i_d sampled at the last posedge since reset, the neg value equals i_d sampled at the last negedge since reset, and RST_VAL while i_rst=1.
- With DFF_EDGE_CNT_EN, CNT_W=2: 5 enabled cycles after reset -> o_cnt_pos = o_cnt_neg = 1 (wrap); assert i_rst -> both counters 0 immediately.
